// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the two lanes of the HLS master bus.
// Define MEM_ARB_STATS_EN to add saturating grant/stall counters (stat_grants0/1, stat_stall).
module mem_port_arbiter #(
    parameter int ADDR_W          = 7,
    parameter int DATA_W          = 8,
    parameter int SIZE_W          = 4,
    parameter int MEM_DELAY_READ  = 2,
    parameter int MEM_DELAY_WRITE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [2*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [2*SIZE_W-1:0]   Mout_data_ram_size,
    output logic [2*DATA_W-1:0]   M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  proto_err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_grants0,
    output logic [31:0]           stat_grants1,
    output logic [31:0]           stat_stall
`endif
);

    localparam int CNT_MAX = (MEM_DELAY_READ > MEM_DELAY_WRITE) ? MEM_DELAY_READ : MEM_DELAY_WRITE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bit i is set when i < size, so size 0 gives no bits and size >= DATA_W gives all bits.
    function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i < int'(size));
        end
        return m;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                lane_q, lane_d;
    logic                dir_q, dir_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                proto_err_q, proto_err_d;

    logic [1:0]          pending;
    logic                grant_vld;
    logic                grant_lane;
    logic [1:0]          grant_mask;

    // A lane asserting oe and we together is malformed and never counts as pending.
    assign pending = Mout_oe_ram ^ Mout_we_ram;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        lane_d       = lane_q;
        dir_d        = dir_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        rdata_d      = rdata_q;
        proto_err_d  = proto_err_q | (|(Mout_oe_ram & Mout_we_ram));
        grant_vld    = 1'b0;
        grant_lane   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pending) begin
                    grant_vld    = 1'b1;
                    grant_lane   = (pending == 2'b11) ? ~last_grant_q : pending[1];
                    last_grant_d = grant_lane;
                    lane_d       = grant_lane;
                    dir_d        = grant_lane ? Mout_we_ram[1] : Mout_we_ram[0];
                    addr_d       = grant_lane ? Mout_addr_ram[2*ADDR_W-1:ADDR_W]
                                              : Mout_addr_ram[ADDR_W-1:0];
                    wdata_d      = grant_lane ? Mout_Wdata_ram[2*DATA_W-1:DATA_W]
                                              : Mout_Wdata_ram[DATA_W-1:0];
                    size_d       = grant_lane ? Mout_data_ram_size[2*SIZE_W-1:SIZE_W]
                                              : Mout_data_ram_size[SIZE_W-1:0];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (dir_q) begin
                    if (MEM_DELAY_WRITE == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(MEM_DELAY_WRITE - 1);
                        state_d = WAIT;
                    end
                end else begin
                    cnt_d   = CNT_W'(MEM_DELAY_READ);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // The last WAIT cycle of a read is exactly MEM_DELAY_READ cycles after ISSUE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    if (!dir_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            lane_q       <= 1'b0;
            dir_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            lane_q       <= lane_d;
            dir_q        <= dir_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            proto_err_q  <= proto_err_d;
        end
        rdata_q <= rdata_d;
    end

    // Memory-side buses hold their registered values; only mem_en/mem_we qualify them.
    always_comb begin
        mem_en      = (state_q == ISSUE);
        mem_we      = (state_q == ISSUE) && dir_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        mem_wmask   = size_mask(size_q);
        proto_err   = proto_err_q;
        M_DataRdy   = 2'b00;
        M_Rdata_ram = '0;
        if (state_q == RESP) begin
            M_DataRdy[lane_q] = 1'b1;
            if (!dir_q) begin
                if (lane_q) begin
                    M_Rdata_ram[2*DATA_W-1:DATA_W] = rdata_q & size_mask(size_q);
                end else begin
                    M_Rdata_ram[DATA_W-1:0] = rdata_q & size_mask(size_q);
                end
            end
        end
    end

    assign grant_mask = grant_vld ? (grant_lane ? 2'b10 : 2'b01) : 2'b00;

`ifdef MEM_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stat_grants0_q, stat_grants0_d;
    logic [31:0] stat_grants1_q, stat_grants1_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_grants0_d = stat_grants0_q;
        stat_grants1_d = stat_grants1_q;
        stat_stall_d   = stat_stall_q;
        if (grant_mask[0]) begin
            stat_grants0_d = sat_inc(stat_grants0_q);
        end
        if (grant_mask[1]) begin
            stat_grants1_d = sat_inc(stat_grants1_q);
        end
        // One count per cycle in which some pending lane was left waiting.
        if (|(pending & ~grant_mask)) begin
            stat_stall_d = sat_inc(stat_stall_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_grants0_q <= '0;
            stat_grants1_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_grants0_q <= stat_grants0_d;
            stat_grants1_q <= stat_grants1_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_grants0 = stat_grants0_q;
    assign stat_grants1 = stat_grants1_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory, two lane requesters and a DataRdy monitor.
module tb_mem_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int RD = 2;
    localparam int WR = 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        oe, we;
    logic [2*AW-1:0]   addr_bus;
    logic [2*DW-1:0]   wdata_bus;
    logic [2*SW-1:0]   size_bus;
    logic [2*DW-1:0]   M_Rdata_ram;
    logic [1:0]        M_DataRdy;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_wmask, mem_rdata;
    logic              proto_err;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]       stat_grants0, stat_grants1, stat_stall;
`endif

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
        .MEM_DELAY_READ(RD), .MEM_DELAY_WRITE(WR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .Mout_oe_ram(oe),
        .Mout_we_ram(we),
        .Mout_addr_ram(addr_bus),
        .Mout_Wdata_ram(wdata_bus),
        .Mout_data_ram_size(size_bus),
        .M_Rdata_ram(M_Rdata_ram),
        .M_DataRdy(M_DataRdy),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .proto_err(proto_err)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_grants0(stat_grants0),
        .stat_grants1(stat_grants1),
        .stat_stall(stat_stall)
`endif
    );

    initial forever #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          c;
        logic [AW-1:0] a;
        logic        w;
        logic [DW-1:0] m;
        logic [DW-1:0] d;
    } en_t;

    int          n_chk, n_pass;
    int          cyc;
    logic [DW-1:0] mem_arr [128];
    logic [DW-1:0] ref_mem [128];
    logic [DW-1:0] rd_pipe [RD];
    logic [DW-1:0] sb0 [$];
    logic [DW-1:0] sb1 [$];
    en_t         en_log [$];
    int          rdy_log [$];
    int          rdy_cyc [$];
    logic [1:0]  prev_rdy;
    logic [DW-1:0] mon_got, mon_oth, mon_exp;
    en_t         e;
    int          t, n_rdy, n_l0;

    assign mem_rdata = rd_pipe[RD-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask_of(input logic [SW-1:0] sz);
        logic [DW-1:0] one;
        one = 8'h01;
        if (sz >= SW'(DW)) return 8'hFF;
        return (one << sz) - 8'h01;
    endfunction

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        oe = 2'b00;
        we = 2'b00;
        repeat (2) sync();
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        check_eq({pfx, "_rdy"},   M_DataRdy, 0);
        check_eq({pfx, "_rdata"}, M_Rdata_ram, 0);
        check_eq({pfx, "_en"},    mem_en, 0);
        check_eq({pfx, "_we"},    mem_we, 0);
        check_eq({pfx, "_addr"},  mem_addr, 0);
        check_eq({pfx, "_wdata"}, mem_wdata, 0);
        check_eq({pfx, "_wmask"}, mem_wmask, 0);
        check_eq({pfx, "_perr"},  proto_err, 0);
    endtask

    // Drive one request on lane ln, push its expected read data, wait for DataRdy, then drop it.
    task automatic lane_txn(input int ln, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] sz,
                            input int exp_lat, output int t_start);
        logic [DW-1:0] m, ex;
        int lat;
        m = mask_of(sz);
        if (wr) begin
            ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            ex = '0;
        end else begin
            ex = ref_mem[a] & m;
        end
        if (ln == 0) sb0.push_back(ex);
        else         sb1.push_back(ex);
        addr_bus[ln*AW +: AW]  = a;
        wdata_bus[ln*DW +: DW] = d;
        size_bus[ln*SW +: SW]  = sz;
        oe[ln] = !wr;
        we[ln] = wr;
        t_start = cyc;
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (M_DataRdy[ln]) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check_eq($sformatf("timeout_lane%0d", ln), lat, exp_lat);
        else if (exp_lat >= 0) check_eq($sformatf("latency_lane%0d", ln), lat, exp_lat);
        sync();
        oe[ln] = 1'b0;
        we[ln] = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        reset = 1'b1; oe = 2'b00; we = 2'b00;
        addr_bus = '0; wdata_bus = '0; size_bus = '0;
        prev_rdy = 2'b00;
        for (int i = 0; i < 128; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < RD; i++) rd_pipe[i] = '0;
        mem_arr[5] = 8'hA7;
        ref_mem[5] = 8'hA7;

        fork
            // Memory model: masked writes, reads returned RD cycles after the mem_en cycle.
            forever begin
                @(posedge clock);
                cyc++;
                for (int k = RD - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
                if (mem_en && !mem_we) rd_pipe[0] <= mem_arr[mem_addr];
                else                   rd_pipe[0] <= 8'h5A;
                if (mem_en && mem_we)
                    mem_arr[mem_addr] = (mem_arr[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            end
            // Monitor: logs issues and pops the scoreboard on every DataRdy.
            forever begin
                @(negedge clock);
                if (reset) begin
                    prev_rdy = 2'b00;
                end else begin
                    if (mem_en) en_log.push_back('{cyc, mem_addr, mem_we, mem_wmask, mem_wdata});
                    if (M_DataRdy != 2'b00) begin
                        check_eq("rdy_onehot", $countones(M_DataRdy), 1);
                        check_eq("rdy_width", prev_rdy, 0);
                        for (int ln = 0; ln < 2; ln++) begin
                            if (M_DataRdy[ln]) begin
                                rdy_log.push_back(ln);
                                rdy_cyc.push_back(cyc);
                                mon_got = M_Rdata_ram[ln*DW +: DW];
                                mon_oth = M_Rdata_ram[(1-ln)*DW +: DW];
                                if (ln == 0 && sb0.size() == 0)      check_eq("rdy_unexp0", sb0.size(), 1);
                                else if (ln == 1 && sb1.size() == 0) check_eq("rdy_unexp1", sb1.size(), 1);
                                else begin
                                    mon_exp = (ln == 0) ? sb0.pop_front() : sb1.pop_front();
                                    check_eq($sformatf("rdata_lane%0d", ln), mon_got, mon_exp);
                                    check_eq($sformatf("rdata_other%0d", ln), mon_oth, 0);
                                end
                            end
                        end
                    end else if (M_Rdata_ram != '0) begin
                        check_eq("rdata_idle", M_Rdata_ram, 0);
                    end
                    prev_rdy = M_DataRdy;
                end
            end
        join_none

        // Reset values
        do_reset();
        @(negedge clock);
        chk_zero("rst");

        // Single read on lane0
        sync();
        en_log.delete();
        lane_txn(0, 1'b0, 7'h05, 8'h00, 4'd8, 2 + RD, t);
        check_eq("t1_en_cnt", en_log.size(), 1);
        if (en_log.size() != 0) begin
            e = en_log.pop_front();
            check_eq("t1_en_cyc", e.c, t + 1);
            check_eq("t1_en_addr", e.a, 7'h05);
            check_eq("t1_en_we", e.w, 0);
        end

        // Write on lane1 with a 4-bit size, then read back
        en_log.delete();
        lane_txn(1, 1'b1, 7'h10, 8'hFF, 4'd4, 1 + WR, t);
        check_eq("t2_en_cnt", en_log.size(), 1);
        if (en_log.size() != 0) begin
            e = en_log.pop_front();
            check_eq("t2_en_cyc", e.c, t + 1);
            check_eq("t2_we", e.w, 1);
            check_eq("t2_wmask", e.m, 8'h0F);
            check_eq("t2_wdata", e.d, 8'hFF);
        end
        lane_txn(1, 1'b0, 7'h10, 8'h00, 4'd8, 2 + RD, t);

        // Size boundaries: 0 writes nothing, >= DATA_W is full width, small read size masks
        en_log.delete();
        lane_txn(0, 1'b1, 7'h20, 8'hC3, 4'd0, 1 + WR, t);
        lane_txn(0, 1'b1, 7'h21, 8'h96, 4'd12, 1 + WR, t);
        check_eq("t2b_en_cnt", en_log.size(), 2);
        if (en_log.size() == 2) begin
            check_eq("t2b_mask0", en_log[0].m, 8'h00);
            check_eq("t2b_mask12", en_log[1].m, 8'hFF);
        end
        lane_txn(0, 1'b0, 7'h21, 8'h00, 4'd3, 2 + RD, t);
        lane_txn(1, 1'b0, 7'h20, 8'h00, 4'd8, 2 + RD, t);
        lane_txn(1, 1'b0, 7'h21, 8'h00, 4'd15, 2 + RD, t);

        // Both lanes read from reset: lane0 first, no overlap
        do_reset();
        en_log.delete(); rdy_log.delete(); rdy_cyc.delete();
        fork
            lane_txn(0, 1'b0, 7'h05, 8'h00, 4'd8, -1, t);
            begin
                int t1;
                lane_txn(1, 1'b0, 7'h21, 8'h00, 4'd8, -1, t1);
            end
        join
        check_eq("t3_rdy_cnt", rdy_log.size(), 2);
        check_eq("t3_en_cnt", en_log.size(), 2);
        if (rdy_log.size() == 2 && en_log.size() == 2) begin
            check_eq("t3_first", rdy_log[0], 0);
            check_eq("t3_second", rdy_log[1], 1);
            check_eq("t3_gap_ok", en_log[1].c > rdy_cyc[0], 1);
        end

        // Continuous requests from both lanes alternate
        do_reset();
        rdy_log.delete();
        fork
            begin
                int ta;
                for (int i = 0; i < 3; i++) begin
                    lane_txn(0, 1'b0, 7'(8'h05 + i), 8'h00, 4'd8, -1, ta);
                    sync();
                end
            end
            begin
                int tb2;
                for (int i = 0; i < 3; i++) begin
                    lane_txn(1, 1'b0, 7'(8'h20 + i), 8'h00, 4'd8, -1, tb2);
                    sync();
                end
            end
        join
        check_eq("t4_rdy_cnt", rdy_log.size(), 6);
        if (rdy_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check_eq($sformatf("t4_alt%0d", i), rdy_log[i], i % 2);
        end
`ifdef MEM_ARB_STATS_EN
        check_eq("t4_grants0", stat_grants0, 3);
        check_eq("t4_grants1", stat_grants1, 3);
`endif

        // oe and we together on lane0 while lane1 reads
        do_reset();
        rdy_log.delete();
        fork
            begin
                oe[0] = 1'b1;
                we[0] = 1'b1;
                @(negedge clock);
                check_eq("t5_perr_before", proto_err, 0);
                @(negedge clock);
                check_eq("t5_perr_after", proto_err, 1);
            end
            begin
                int t5;
                lane_txn(1, 1'b0, 7'h10, 8'h00, 4'd8, 2 + RD, t5);
            end
        join
        repeat (4) sync();
        oe[0] = 1'b0;
        we[0] = 1'b0;
        repeat (3) sync();
        @(negedge clock);
        check_eq("t5_perr_sticky", proto_err, 1);
        n_l0 = 0;
        foreach (rdy_log[i]) if (rdy_log[i] == 0) n_l0++;
        check_eq("t5_lane0_rdy", n_l0, 0);
        do_reset();
        @(negedge clock);
        check_eq("t5_perr_reset", proto_err, 0);

        // Reset during WAIT of a read aborts it
        sync();
        addr_bus[AW-1:0] = 7'h05;
        size_bus[SW-1:0] = 4'd8;
        oe[0] = 1'b1;
        sync();
        sync();
        reset = 1'b1;
        oe[0] = 1'b0;
        sync();
        reset = 1'b0;
        @(negedge clock);
        chk_zero("t6");
        n_rdy = 0;
        repeat (10) begin
            @(negedge clock);
            if (M_DataRdy != 2'b00) n_rdy++;
        end
        check_eq("t6_no_rdy", n_rdy, 0);
        sync();
        lane_txn(1, 1'b0, 7'h05, 8'h00, 4'd8, 2 + RD, t);
        check_eq("sb_drained", sb0.size() + sb1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
